// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: the requester ports C and D, the arbiter results and
// the DataBusControl side, grouped into one bundle.
// slave  = arbiter view, master = requesters plus bus model view.
interface data_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  // port C (core load/store path)
  logic                  c_req;
  logic                  c_wr;
  logic [1:0]            c_size;
  logic                  c_unsigned;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_gnt;
  logic                  c_done;
  logic                  c_err;
  // port D (debug / program loader)
  logic                  d_req;
  logic                  d_wr;
  logic [1:0]            d_size;
  logic                  d_unsigned;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_done;
  logic                  d_err;
  // shared results
  logic [DATA_WIDTH-1:0] rdata;
  logic                  owner;
  // DataBusControl side
  logic                  bus_rd;
  logic                  bus_wd;
  logic [1:0]            bus_size;
  logic                  bus_unsigned;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;

  modport slave (
    input  c_req, c_wr, c_size, c_unsigned, c_addr, c_wdata,
    input  d_req, d_wr, d_size, d_unsigned, d_addr, d_wdata,
    output c_gnt, c_done, c_err, d_gnt, d_done, d_err,
    output rdata, owner,
    output bus_rd, bus_wd, bus_size, bus_unsigned, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport master (
    output c_req, c_wr, c_size, c_unsigned, c_addr, c_wdata,
    output d_req, d_wr, d_size, d_unsigned, d_addr, d_wdata,
    input  c_gnt, c_done, c_err, d_gnt, d_done, d_err,
    input  rdata, owner,
    input  bus_rd, bus_wd, bus_size, bus_unsigned, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares the DataBusControl data port between the core
// load/store path (C) and a secondary master (D). One transaction at a time:
// IDLE -> ISSUE -> WAIT -> DONE, or IDLE -> DONE for misaligned/reserved
// accesses. WAIT is bounded by TIMEOUT cycles. All outputs are registered.
// Build option: define RISCUIN_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// otherwise fixed priority with C winning ties.
module data_bus_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst,
  data_bus_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;

  // latched transaction
  logic                  r_wr;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  // registered outputs
  logic                  r_owner;
  logic                  r_c_gnt;
  logic                  r_d_gnt;
  logic                  r_c_done;
  logic                  r_d_done;
  logic                  r_c_err;
  logic                  r_d_err;
  logic                  r_bus_rd;
  logic                  r_bus_wd;
  logic [DATA_WIDTH-1:0] r_rdata;

  // arbitration / selection
  logic                  w_any_req;
  logic                  w_win;
  logic                  w_sel_wr;
  logic [1:0]            w_sel_size;
  logic                  w_sel_uns;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_misalign;

  // next values for registered outputs
  logic                  w_own_nxt;
  logic                  w_c_gnt_nxt;
  logic                  w_d_gnt_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic                  w_c_done_nxt;
  logic                  w_d_done_nxt;
  logic                  w_c_err_nxt;
  logic                  w_d_err_nxt;
  logic                  w_rd_nxt;
  logic                  w_wd_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;

`ifdef RISCUIN_ARB_ROUND_ROBIN_EN
  logic                  r_last;  // 0 = C served last, 1 = D served last
`endif

  // Winner selection, request field mux and alignment check
  always_comb begin
    w_any_req = io_bus.c_req | io_bus.d_req;
`ifdef RISCUIN_ARB_ROUND_ROBIN_EN
    if (io_bus.c_req && io_bus.d_req) begin
      w_win = ~r_last;
    end else begin
      w_win = ~io_bus.c_req;
    end
`else
    w_win = ~io_bus.c_req;
`endif
    if (w_win) begin
      w_sel_wr    = io_bus.d_wr;
      w_sel_size  = io_bus.d_size;
      w_sel_uns   = io_bus.d_unsigned;
      w_sel_addr  = io_bus.d_addr;
      w_sel_wdata = io_bus.d_wdata;
    end else begin
      w_sel_wr    = io_bus.c_wr;
      w_sel_size  = io_bus.c_size;
      w_sel_uns   = io_bus.c_unsigned;
      w_sel_addr  = io_bus.c_addr;
      w_sel_wdata = io_bus.c_wdata;
    end
    case (w_sel_size)
      2'b01:   w_misalign = w_sel_addr[0];
      2'b10:   w_misalign = |w_sel_addr[1:0];
      2'b11:   w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_misalign ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (io_bus.bus_ready || (r_cnt == LP_CNT_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take next cycle,
  // so every pulse lands in the state it belongs to without comb outputs
  always_comb begin
    w_own_nxt   = r_owner;
    w_c_gnt_nxt = 1'b0;
    w_d_gnt_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_nxt    = 1'b0;
    w_wd_nxt    = 1'b0;
    w_rdata_nxt = '0;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_own_nxt   = w_win;
          w_c_gnt_nxt = ~w_win;
          w_d_gnt_nxt = w_win;
          if (w_misalign) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            w_rd_nxt = ~w_sel_wr;
            w_wd_nxt = w_sel_wr;
          end
        end
      end
      S_WAIT: begin
        if (io_bus.bus_ready) begin
          w_done_nxt = 1'b1;
          if (!r_wr) begin
            w_rdata_nxt = io_bus.bus_rdata;
          end
        end else if (r_cnt == LP_CNT_LAST) begin
          w_done_nxt = 1'b1;
          w_err_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    w_c_done_nxt = w_done_nxt & ~w_own_nxt;
    w_d_done_nxt = w_done_nxt & w_own_nxt;
    w_c_err_nxt  = w_err_nxt & ~w_own_nxt;
    w_d_err_nxt  = w_err_nxt & w_own_nxt;
  end

  // Output and wait-counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_c_gnt  <= 1'b0;
      r_d_gnt  <= 1'b0;
      r_c_done <= 1'b0;
      r_d_done <= 1'b0;
      r_c_err  <= 1'b0;
      r_d_err  <= 1'b0;
      r_bus_rd <= 1'b0;
      r_bus_wd <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_owner  <= w_own_nxt;
      r_c_gnt  <= w_c_gnt_nxt;
      r_d_gnt  <= w_d_gnt_nxt;
      r_c_done <= w_c_done_nxt;
      r_d_done <= w_d_done_nxt;
      r_c_err  <= w_c_err_nxt;
      r_d_err  <= w_d_err_nxt;
      r_bus_rd <= w_rd_nxt;
      r_bus_wd <= w_wd_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  // Latch the winning request; held for the whole transaction so req changes
  // after the grant cannot disturb the bus fields
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_wr    <= w_sel_wr;
      r_size  <= w_sel_size;
      r_uns   <= w_sel_uns;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

`ifdef RISCUIN_ARB_ROUND_ROBIN_EN
  // Last-served tracking; resets to D so C takes the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= 1'b1;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_last <= w_win;
    end
  end
`endif

  assign io_bus.c_gnt        = r_c_gnt;
  assign io_bus.d_gnt        = r_d_gnt;
  assign io_bus.c_done       = r_c_done;
  assign io_bus.d_done       = r_d_done;
  assign io_bus.c_err        = r_c_err;
  assign io_bus.d_err        = r_d_err;
  assign io_bus.rdata        = r_rdata;
  assign io_bus.owner        = r_owner;
  assign io_bus.bus_rd       = r_bus_rd;
  assign io_bus.bus_wd       = r_bus_wd;
  assign io_bus.bus_size     = r_size;
  assign io_bus.bus_unsigned = r_uns;
  assign io_bus.bus_addr     = r_addr;
  assign io_bus.bus_wdata    = r_wdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: table of single transactions checked through a
// scoreboard queue, plus hand-written reset, arbitration and abort sequences.
`timescale 1ns/1ps
module tb_data_bus_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int TO    = 16;
  localparam int NEVER = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bif.slave)
  );

  typedef struct {
    bit          port;    // 0 = C, 1 = D
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          delay;   // extra WAIT cycles before ready, NEVER = no ready
    logic [31:0] brdata;
    bit          err;
    logic [31:0] rdata;
    int          lat;     // done cycle relative to drive cycle
    bit          strb;    // number of bus strobes expected (0/1)
  } vec_t;

  typedef struct {
    bit          own;
    bit          err;
    logic [31:0] rdata;
    int          done_cyc;
    bit          strb;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wdata;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   strobes_seen = 0;
  exp_t sb[$];

  int          rsp_delay = 0;
  logic [31:0] rsp_data = '0;
  int          rsp_cnt = -1;

  vec_t vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus model: ready arrives rsp_delay WAIT cycles after the strobe
  initial begin
    bif.bus_ready = 1'b0;
    bif.bus_rdata = 32'hF0F0_0F0F;
    forever begin
      @(negedge clk);
      bif.bus_ready = 1'b0;
      bif.bus_rdata = 32'hF0F0_0F0F;
      if (!rst) begin
        rsp_cnt = -1;
      end else begin
        if (rsp_cnt == 0) begin
          bif.bus_ready = 1'b1;
          bif.bus_rdata = rsp_data;
          rsp_cnt = -1;
        end else if (rsp_cnt > 0) begin
          rsp_cnt--;
        end
        if ((bif.bus_rd || bif.bus_wd) && rsp_delay != NEVER) rsp_cnt = rsp_delay;
      end
    end
  end

  // Monitor: strobe fields and done results against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bif.bus_rd || bif.bus_wd) begin
        strobes_seen++;
        if (sb.size() == 0) begin
          check("strobe_unexpected", 64'(1), 64'(0));
        end else begin
          check("bus_addr", 64'(bif.bus_addr), 64'(sb[0].addr));
          check("bus_dir", 64'({bif.bus_rd, bif.bus_wd}), sb[0].wr ? 64'(2'b01) : 64'(2'b10));
          check("bus_size", 64'(bif.bus_size), 64'(sb[0].size));
          check("bus_unsigned", 64'(bif.bus_unsigned), 64'(sb[0].uns));
          if (sb[0].wr) check("bus_wdata", 64'(bif.bus_wdata), 64'(sb[0].wdata));
        end
      end
      if (bif.c_done || bif.d_done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("done_port", 64'({bif.c_done, bif.d_done}), e.own ? 64'(2'b01) : 64'(2'b10));
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("err_port", 64'({bif.c_err, bif.d_err}),
                e.err ? (e.own ? 64'(2'b01) : 64'(2'b10)) : 64'(0));
          check("rdata", 64'(bif.rdata), 64'(e.rdata));
          check("strobe_count", 64'(strobes_seen), 64'(e.strb));
        end
        strobes_seen = 0;
      end
    end
  end

  // Drive actions 2ns after the negedge so the monitor has already sampled
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    int waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      step();
      waited++;
    end
    if (sb.size() != 0) begin
      check({tag, "_done_timeout"}, 64'(0), 64'(1));
      sb.delete();
    end
    step();
  endtask

  task automatic drive_port(input bit port, input bit wr, input logic [1:0] size, input bit uns,
                            input logic [11:0] addr, input logic [31:0] wdata);
    if (port) begin
      bif.d_wr = wr; bif.d_size = size; bif.d_unsigned = uns; bif.d_addr = addr; bif.d_wdata = wdata;
    end else begin
      bif.c_wr = wr; bif.c_size = size; bif.c_unsigned = uns; bif.c_addr = addr; bif.c_wdata = wdata;
    end
  endtask

  task automatic push_exp(input bit own, input bit err, input logic [31:0] rdata, input int done_cyc,
                          input bit strb, input bit wr, input logic [1:0] size, input bit uns,
                          input logic [11:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.own = own; e.err = err; e.rdata = rdata; e.done_cyc = done_cyc; e.strb = strb;
    e.wr = wr; e.size = size; e.uns = uns; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    rsp_delay = v.delay;
    rsp_data  = v.brdata;
    drive_port(v.port, v.wr, v.size, v.uns, v.addr, v.wdata);
    k = cyc;
    push_exp(v.port, v.err, v.rdata, k + v.lat, v.strb, v.wr, v.size, v.uns, v.addr, v.wdata);
    if (v.port) bif.d_req = 1'b1; else bif.c_req = 1'b1;
    step();
    check($sformatf("v%0d_gnt", idx), 64'({bif.c_gnt, bif.d_gnt}), v.port ? 64'(2'b01) : 64'(2'b10));
    check($sformatf("v%0d_owner", idx), 64'(bif.owner), 64'(v.port));
    bif.c_req = 1'b0;
    bif.d_req = 1'b0;
    wait_done($sformatf("v%0d", idx));
  endtask

  initial begin
    int k;
    int gcount;
    bit own_exp[4];

    //          port wr size  uns addr     wdata         delay brdata        err rdata         lat strb
    vecs[0] = '{1'b0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF,  3, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 1'b0, 12'h022, 32'h0000BEEF, 3, 32'h12345678, 1'b0, 32'h0,         6, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 2'b10, 1'b0, 12'h013, 32'h0,        0, 32'h55555555, 1'b1, 32'h0,         1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 2'b11, 1'b0, 12'h010, 32'h1,        0, 32'h55555555, 1'b1, 32'h0,         1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 12'h021, 32'h0,        0, 32'h55555555, 1'b1, 32'h0,         1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 12'h023, 32'h0,        1, 32'h000000AB, 1'b0, 32'h000000AB,  4, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 2'b10, 1'b0, 12'h040, 32'h0,    NEVER, 32'h0,        1'b1, 32'h0,     2 + TO, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b0, 12'h0FC, 32'hCAFEF00D, TO - 1, 32'h77777777, 1'b0, 32'h0, 3 + TO - 1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 2'b01, 1'b1, 12'h002, 32'h0,        0, 32'h0000FFFF, 1'b0, 32'h0000FFFF,  3, 1'b1};

    // reset held with both requests active
    rst = 1'b0;
    bif.c_req = 1'b1;
    bif.d_req = 1'b1;
    drive_port(1'b0, 1'b0, 2'b10, 1'b0, 12'h100, 32'h0);
    drive_port(1'b1, 1'b0, 2'b10, 1'b0, 12'h200, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_ctrl", 64'({bif.c_gnt, bif.d_gnt, bif.c_done, bif.d_done, bif.c_err, bif.d_err,
                               bif.owner, bif.bus_rd, bif.bus_wd, bif.bus_unsigned, bif.bus_size}), 64'(0));
      check("reset_rdata", 64'(bif.rdata), 64'(0));
      check("reset_bus_addr", 64'(bif.bus_addr), 64'(0));
      check("reset_bus_wdata", 64'(bif.bus_wdata), 64'(0));
    end
    rsp_delay = 0;
    rsp_data  = 32'h11111111;
    k = cyc;
    push_exp(1'b0, 1'b0, 32'h11111111, k + 3, 1'b1, 1'b0, 2'b10, 1'b0, 12'h100, 32'h0);
    rst = 1'b1;
    step();
    check("post_reset_gnt", 64'({bif.c_gnt, bif.d_gnt}), 64'(2'b10));
    bif.c_req = 1'b0;
    bif.d_req = 1'b0;
    wait_done("post_reset");

    // table-driven single transactions
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // both requests held across four transactions, zero-wait bus
`ifdef RISCUIN_ARB_ROUND_ROBIN_EN
    own_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    own_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    drive_port(1'b0, 1'b0, 2'b10, 1'b0, 12'h200, 32'h0);
    drive_port(1'b1, 1'b0, 2'b10, 1'b0, 12'h300, 32'h0);
    rsp_delay = 0;
    rsp_data  = 32'h0A0B0C0D;
    k = cyc;
    for (int i = 0; i < 4; i++)
      push_exp(own_exp[i], 1'b0, 32'h0A0B0C0D, k + 3 + 4 * i, 1'b1, 1'b0, 2'b10, 1'b0,
               own_exp[i] ? 12'h300 : 12'h200, 32'h0);
    bif.c_req = 1'b1;
    bif.d_req = 1'b1;
    gcount = 0;
    for (int j = 0; j < 20 && gcount < 4; j++) begin
      step();
      if (bif.c_gnt || bif.d_gnt) begin
        check($sformatf("arb_gnt%0d", gcount), 64'({bif.c_gnt, bif.d_gnt}),
              own_exp[gcount] ? 64'(2'b01) : 64'(2'b10));
        check($sformatf("arb_gnt_cycle%0d", gcount), 64'(cyc), 64'(k + 1 + 4 * gcount));
        gcount++;
      end
    end
    check("arb_gnt_count", 64'(gcount), 64'(4));
    bif.c_req = 1'b0;
    bif.d_req = 1'b0;
    wait_done("arb");

    // reset in the middle of a waiting transaction
    rsp_delay = NEVER;
    drive_port(1'b0, 1'b0, 2'b10, 1'b0, 12'h044, 32'h0);
    k = cyc;
    push_exp(1'b0, 1'b1, 32'h0, -1, 1'b1, 1'b0, 2'b10, 1'b0, 12'h044, 32'h0);
    bif.c_req = 1'b1;
    step();
    check("abort_gnt", 64'({bif.c_gnt, bif.d_gnt}), 64'(2'b10));
    bif.c_req = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    check("abort_ctrl", 64'({bif.c_gnt, bif.d_gnt, bif.c_done, bif.d_done, bif.c_err, bif.d_err,
                             bif.owner, bif.bus_rd, bif.bus_wd}), 64'(0));
    check("abort_bus_addr", 64'(bif.bus_addr), 64'(0));
    rst = 1'b1;
    repeat (TO + 4) step();
    check("abort_no_done", 64'(sb.size()), 64'(1));
    sb.delete();
    strobes_seen = 0;

    // arbiter back in IDLE: a fresh transaction runs normally
    run_vec(vecs[0], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    bif.c_req = 1'b0; bif.d_req = 1'b0;
    bif.c_wr = 1'b0; bif.c_size = 2'b00; bif.c_unsigned = 1'b0; bif.c_addr = '0; bif.c_wdata = '0;
    bif.d_wr = 1'b0; bif.d_size = 2'b00; bif.d_unsigned = 1'b0; bif.d_addr = '0; bif.d_wdata = '0;
  end
endmodule
